instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 6, instruction-memory address width; capacity DEPTH = 2**ADDR_W words.
REQ-002 Parameter BASE_ADDR, default 0, first write address after start.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that opens a load session.
REQ-006 in_valid  input  1  instruction fields present.
REQ-007 in_ready  output  1  block accepts the fields this cycle.
REQ-008 in_op  input  2  class: 00 data, 01 memory, 10 branch, 11 illegal.
REQ-009 in_funct  input  4  bit0 immediate, bit1 flag-set or load, bits3:2 ALU command.
REQ-010 in_rd / in_rn  input  4 each  destination and first-source register.
REQ-011 in_src2  input  24  immediate, register number in bits3:0, or branch offset.
REQ-012 mem_we  output  1  instruction-memory write strobe.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  32  encoded instruction word.
REQ-015 busy  output  1  session open.
REQ-016 full  output  1  DEPTH words written.
REQ-017 err  output  1  one-cycle pulse when an instruction is rejected.
REQ-018 count  output  ADDR_W+1  words written this session.

Function
REQ-019 FSM states: IDLE, ACCEPT, WRITE, FULL.
REQ-020 IDLE: in_ready=0; start moves to ACCEPT, sets the address to BASE_ADDR and clears count.
REQ-021 ACCEPT: in_ready=1; an in_valid&in_ready cycle latches the fields and moves to WRITE.
REQ-022 WRITE: in_ready=0 and mem_we=1 for exactly one cycle, one cycle after acceptance.
- After WRITE: address+1 and count+1.
- Next state is FULL if count reaches DEPTH, else ACCEPT.
REQ-023 Encoding for data and memory classes:
- [31:28]=4'hE (always).
- [27:26]=op, [25:22]=funct, [21:18]=rn, [17:14]=rd.
- [13:0]=src2[13:0] when funct[0]=1, else {10'b0, src2[3:0]}.
REQ-024 Encoding for the branch class: [31:28]=4'hE, [27:26]=2'b10, [25:24]=2'b00, [23:0]=src2.
REQ-025 Rejection cases: in_op=11, or funct[0]=1 with in_src2[23:14]!=0 for the data or memory class.
- The fields are accepted (handshake completes) and err pulses on the next cycle.
- No write occurs and the FSM stays in ACCEPT.
REQ-026 rd=15 with the data class is encoded normally, without a check.
REQ-027 FULL: in_ready=0 and full=1; only start leaves FULL, moving to ACCEPT with the address and count cleared.
REQ-028 start in ACCEPT restarts the session.
REQ-029 start in WRITE lets the pending write complete first; the restart then takes effect in the following cycle.
REQ-030 Address wrap: mem_addr is BASE_ADDR plus count, modulo DEPTH.
REQ-031 busy=1 in ACCEPT, WRITE and FULL.

Reset
REQ-032 While rst_n=0 the block is in IDLE, independent of clk.
REQ-033 Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, full=0, err=0, count=0.
REQ-034 Reset asserted during WRITE aborts the write: mem_we drops asynchronously.

Structure
REQ-035 Shared package instr_pkg holds:
- the op class enum;
- the COND_AL constant;
- the field bit-position constants;
- the FSM state typedef.
REQ-036 Packing and legality check form a combinational sub-module instr_pack, instantiated once.

Verification
REQ-037 start; op=00, funct=0001, rn=1, rd=2, src2=5 -> mem_we one cycle after acceptance, addr 0, wdata 0xE0448005, count 1.
REQ-038 op=10, src2=0x000010 -> wdata 0xE8000010.
REQ-039 op=11, or op=00 with funct=0001 and src2=0x004000 -> err pulse, no mem_we, count unchanged, in_ready high again.
REQ-040 64 back-to-back valid instructions -> addresses 0..63, one write every 2 cycles, full=1 and in_ready=0 after the last; a 65th is not accepted.
REQ-041 rst_n low during WRITE -> mem_we falls immediately; all outputs at their reset values.
REQ-042 start while FULL -> full=0, count=0, next write at BASE_ADDR.

Source files
------------

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and field positions for the instruction loader
package instr_pkg;

  typedef enum logic [1:0] {
    OP_DATA    = 2'b00,
    OP_MEM     = 2'b01,
    OP_BRANCH  = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_FULL
  } state_e;

  localparam logic [3:0] COND_AL = 4'hE;

  localparam int COND_LSB  = 28;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_LSB = 22;
  localparam int RN_LSB    = 18;
  localparam int RD_LSB    = 14;
  localparam int IMM_W     = 14;
  localparam int SRC2_W    = 24;

  typedef struct packed {
    op_class_e         op;
    logic [3:0]        funct;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [SRC2_W-1:0] src2;
  } instr_fields_t;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - valid/ready handshake carrying raw instruction fields
interface instr_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [3:0]  in_funct;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [23:0] in_src2;

  modport master (
    output in_valid, in_op, in_funct, in_rd, in_rn, in_src2,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_funct, in_rd, in_rn, in_src2,
    output in_ready
  );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational encoder and legality check for one instruction
module instr_pack
  import instr_pkg::*;
(
  input  instr_fields_t fields_i,
  output logic [31:0]   word_o,
  output logic          reject_o
);

  always_comb begin
    word_o   = '0;
    reject_o = 1'b0;
    case (fields_i.op)
      OP_BRANCH: begin
        word_o = {COND_AL, 2'(OP_BRANCH), 2'b00, fields_i.src2};
      end
      OP_ILLEGAL: begin
        reject_o = 1'b1;
      end
      default: begin
        word_o[COND_LSB +: 4]  = COND_AL;
        word_o[OP_LSB +: 2]    = fields_i.op;
        word_o[FUNCT_LSB +: 4] = fields_i.funct;
        word_o[RN_LSB +: 4]    = fields_i.rn;
        word_o[RD_LSB +: 4]    = fields_i.rd;
        // Immediate form must fit the 14-bit field; register form only keeps the register number.
        if (fields_i.funct[0]) begin
          word_o[IMM_W-1:0] = fields_i.src2[IMM_W-1:0];
          reject_o          = |fields_i.src2[SRC2_W-1:IMM_W];
        end else begin
          word_o[3:0] = fields_i.src2[3:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - accepts instruction fields, encodes them and writes them to instruction memory
module instr_loader
  import instr_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_loader_if.slave     in_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              full_q;
  logic              err_q;
  logic [ADDR_W:0]   count_q;

  instr_fields_t fields;
  logic [31:0]   word;
  logic          reject;
  logic [ADDR_W:0] count_inc;

  assign fields = '{
    op:    op_class_e'(in_if.in_op),
    funct: in_if.in_funct,
    rd:    in_if.in_rd,
    rn:    in_if.in_rn,
    src2:  in_if.in_src2
  };

  assign count_inc = count_q + 1'b1;

  instr_pack u_pack (
    .fields_i (fields),
    .word_o   (word),
    .reject_o (reject)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_ACCEPT;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
          end
        end
        ST_ACCEPT: begin
          if (start) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
          end
          // A handshake coinciding with a restart becomes the first word of the new session.
          if (in_if.in_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              state_q    <= ST_WRITE;
              in_ready_q <= 1'b0;
              mem_we_q   <= 1'b1;
              wdata_q    <= word;
            end
          end
        end
        ST_WRITE: begin
          if (start) begin
            state_q    <= ST_ACCEPT;
            in_ready_q <= 1'b1;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
          end else begin
            addr_q  <= addr_q + 1'b1;
            count_q <= count_inc;
            if (count_inc == DEPTH_C) begin
              state_q <= ST_FULL;
              full_q  <= 1'b1;
            end else begin
              state_q    <= ST_ACCEPT;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (start) begin
            state_q    <= ST_ACCEPT;
            in_ready_q <= 1'b1;
            full_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;
  assign full           = full_q;
  assign err            = err_q;
  assign count          = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed vector bench for instr_loader
module tb_instr_loader;
  import instr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        full;
  logic        err;
  logic [6:0]  count;

  instr_loader_if bus ();

  instr_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_if     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .full      (full),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] src2;
    bit          rej;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[9];
  int   n_run = 0;
  int   n_fail = 0;
  int   exp_count = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send(input vec_t v);
    wait_ready();
    bus.in_op    = v.op;
    bus.in_funct = v.funct;
    bus.in_rn    = v.rn;
    bus.in_rd    = v.rd;
    bus.in_src2  = v.src2;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (!v.rej) begin
      check("mem_we_on", 32'(mem_we), 32'd1);
      check("mem_addr", 32'(mem_addr), 32'(exp_count));
      check("mem_wdata", mem_wdata, v.word);
      check("ready_low_in_write", 32'(bus.in_ready), 32'd0);
      tick();
      exp_count++;
      check("mem_we_off", 32'(mem_we), 32'd0);
      check("count_after_write", 32'(count), 32'(exp_count));
    end else begin
      check("err_pulse", 32'(err), 32'd1);
      check("no_we_on_err", 32'(mem_we), 32'd0);
      check("ready_after_err", 32'(bus.in_ready), 32'd1);
      tick();
      check("err_cleared", 32'(err), 32'd0);
      check("count_on_err", 32'(count), 32'(exp_count));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_count = 0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
  endtask

  initial begin
    vec_t fv;
    vecs[0] = '{2'b00, 4'b0001, 4'd1,  4'd2,  24'h000005, 1'b0, 32'hE0448005};
    vecs[1] = '{2'b10, 4'b0000, 4'd0,  4'd0,  24'h000010, 1'b0, 32'hE8000010};
    vecs[2] = '{2'b01, 4'b0010, 4'd3,  4'd4,  24'h00ABC7, 1'b0, 32'hE48D0007};
    vecs[3] = '{2'b00, 4'b1101, 4'd15, 4'd15, 24'h003FFF, 1'b0, 32'hE37FFFFF};
    vecs[4] = '{2'b11, 4'b0000, 4'd1,  4'd1,  24'h000001, 1'b1, 32'h0};
    vecs[5] = '{2'b00, 4'b0001, 4'd1,  4'd2,  24'h004000, 1'b1, 32'h0};
    vecs[6] = '{2'b01, 4'b0001, 4'd0,  4'd0,  24'h800000, 1'b1, 32'h0};
    vecs[7] = '{2'b10, 4'b1111, 4'd7,  4'd7,  24'hFFFFFF, 1'b0, 32'hE8FFFFFF};
    vecs[8] = '{2'b00, 4'b0000, 4'd0,  4'd0,  24'hFFFFF5, 1'b0, 32'hE0000005};

    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_funct = '0;
    bus.in_rn    = '0;
    bus.in_rd    = '0;
    bus.in_src2  = '0;

    #3;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(bus.in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    pulse_start();
    check("start_ready", 32'(bus.in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_count", 32'(count), 32'd0);

    for (int i = 0; i < 9; i++) send(vecs[i]);

    // restart from ACCEPT
    pulse_start();
    check("restart_count", 32'(count), 32'd0);
    send(vecs[0]);

    // start arriving during WRITE: the write lands, then the session restarts
    wait_ready();
    bus.in_op = 2'b10; bus.in_src2 = 24'h000010; bus.in_funct = 4'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    start = 1'b1;
    check("wr_start_we", 32'(mem_we), 32'd1);
    check("wr_start_addr", 32'(mem_addr), 32'd1);
    tick();
    start = 1'b0;
    exp_count = 0;
    check("wr_start_count", 32'(count), 32'd0);
    check("wr_start_ready", 32'(bus.in_ready), 32'd1);
    check("wr_start_we_off", 32'(mem_we), 32'd0);
    send(vecs[2]);

    // fill all 64 words back to back
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      fv = '{2'b00, 4'b0001, 4'd0, 4'd0, 24'(i), 1'b0, 32'hE0400000 | 32'(i)};
      send(fv);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_count", 32'(count), 32'd64);
    check("full_busy", 32'(busy), 32'd1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_65th_we", 32'(mem_we), 32'd0);
      check("no_65th_count", 32'(count), 32'd64);
    end
    bus.in_valid = 1'b0;

    pulse_start();
    check("unfull_flag", 32'(full), 32'd0);
    check("unfull_count", 32'(count), 32'd0);
    check("unfull_ready", 32'(bus.in_ready), 32'd1);
    send(vecs[1]);

    // asynchronous reset in the middle of a write
    wait_ready();
    bus.in_op = 2'b00; bus.in_funct = 4'b0001; bus.in_src2 = 24'h000005;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_we", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
